uart_rx_pkt_ctrl: RTL and testbench

//  Packet controller behind the 8N1 UART receiver. Takes the receiver's byte

---
 rtl/uart_rx_pkt_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Framed write-command parser (SYNC, ADDR, LEN, payload, CHK) feeding the register bank.
// Latency: first register write 1 cycle after the CHK byte; pkt_done/pkt_err one cycle after the deciding event.
// Backpressure: none; bytes are strobed in, and bytes arriving during COMMIT are dropped.
module uart_rx_pkt_ctrl #(
    parameter int         CLK_FREQ      = 100_000_000,
    parameter int         BAUD_RATE     = 9_600,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         ADDR_W        = 4,
    parameter int         MAX_LEN       = 8,
    parameter int         TIMEOUT_BYTES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_frame_err,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam longint unsigned TO_LIMIT =
        (longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ)) / longint'(BAUD_RATE);
    localparam int TO_W  = $clog2(TO_LIMIT + 1);
    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int BI_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BUF_D = 1 << BI_W;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [TO_W-1:0]  TMR_ONE = TO_W'(1);
    localparam logic [TO_W-1:0]  TMR_END = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_COMMIT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [IDX_W-1:0]  len, len_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [7:0]        chk, chk_n;
    logic [TO_W-1:0]   tmr, tmr_n;
    logic              buf_we;
    logic              done_n, err_n;
    logic [1:0]        code_n;
    logic [7:0]        pbuf [BUF_D];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            chk      <= '0;
            tmr      <= '0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 2'd0;
            for (int i = 0; i < BUF_D; i++) begin
                pbuf[i] <= 8'd0;
            end
        end else begin
            state    <= state_n;
            base     <= base_n;
            len      <= len_n;
            idx      <= idx_n;
            chk      <= chk_n;
            tmr      <= tmr_n;
            pkt_done <= done_n;
            pkt_err  <= err_n;
            err_code <= code_n;
            if (buf_we) begin
                pbuf[idx[BI_W-1:0]] <= rx_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        base_n  = base;
        len_n   = len;
        idx_n   = idx;
        chk_n   = chk;
        tmr_n   = '0;
        buf_we  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = 2'd0;

        case (state)
            ST_IDLE: begin
                if (rx_valid && !rx_frame_err && rx_data == SYNC_BYTE) begin
                    state_n = ST_ADDR;
                end
            end

            ST_ADDR, ST_LEN, ST_DATA, ST_CHK: begin
                if (rx_valid && rx_frame_err) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                    code_n  = 2'd3;
                end else if (rx_valid) begin
                    // A byte arriving on the timeout cycle is taken, so this branch outranks the timer.
                    case (state)
                        ST_ADDR: begin
                            if ((rx_data >> ADDR_W) != 8'd0) begin
                                state_n = ST_IDLE;
                                err_n   = 1'b1;
                                code_n  = 2'd1;
                            end else begin
                                base_n  = rx_data[ADDR_W-1:0];
                                chk_n   = rx_data;
                                state_n = ST_LEN;
                            end
                        end
                        ST_LEN: begin
                            if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
                                len_n   = rx_data[IDX_W-1:0];
                                chk_n   = chk ^ rx_data;
                                idx_n   = '0;
                                state_n = ST_DATA;
                            end else begin
                                state_n = ST_IDLE;
                                err_n   = 1'b1;
                                code_n  = 2'd1;
                            end
                        end
                        ST_DATA: begin
                            buf_we = 1'b1;
                            chk_n  = chk ^ rx_data;
                            idx_n  = idx + IDX_ONE;
                            if (idx + IDX_ONE == len) begin
                                state_n = ST_CHK;
                            end
                        end
                        ST_CHK: begin
                            if (rx_data == chk) begin
                                idx_n   = '0;
                                state_n = ST_COMMIT;
                            end else begin
                                state_n = ST_IDLE;
                                err_n   = 1'b1;
                                code_n  = 2'd0;
                            end
                        end
                        default: ;
                    endcase
                end else if (tmr == TMR_END) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                end else begin
                    tmr_n = tmr + TMR_ONE;
                end
            end

            ST_COMMIT: begin
                if (idx == len - IDX_ONE) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + IDX_ONE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // Writes are driven straight from the COMMIT state so the first lands one cycle after CHK.
    assign busy      = (state != ST_IDLE);
    assign reg_wr_en = (state == ST_COMMIT);
    assign reg_addr  = reg_wr_en ? base + ADDR_W'(idx) : '0;
    assign reg_wdata = reg_wr_en ? pbuf[idx[BI_W-1:0]] : 8'd0;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Randomised bench for uart_rx_pkt_ctrl: a packet-level model queues expected writes/results,
// and a monitor pops and compares them whenever the DUT presents an output.
module tb_uart_rx_pkt_ctrl;

    localparam int         CLK_FREQ  = 1_000_000;
    localparam int         BAUD_RATE = 100_000;
    localparam int         TOB       = 3;
    localparam int         MAX_LEN   = 8;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         TO_CYC    = TOB * 10 * CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_frame_err = 1'b0;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_pkt_ctrl #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .SYNC_BYTE(SYNC),
        .ADDR_W(4), .MAX_LEN(MAX_LEN), .TIMEOUT_BYTES(TOB)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_frame_err(rx_frame_err), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 register write, 1 packet done, 2 packet error
    typedef struct {
        int kind;
        int addr;
        int data;
        int code;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    bit         wr_lat_pend = 1'b0;
    int         wr_lat_cyc = 0;
    logic [7:0] pb[$];
    bit         pf[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int k, input int a, input int d, input int c);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d; e.code = c;
        sbq.push_back(e);
    endtask

    task automatic expect_evt(input int k, input int a, input int d, input int c);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual kind=%0d addr=%0h data=%0h code=%0d required=no event",
                     k, a, d, c);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.addr != a || e.data != d || e.code != c) begin
                failures++;
                $display("FAIL sb_event actual kind=%0d addr=%0h data=%0h code=%0d required kind=%0d addr=%0h data=%0h code=%0d",
                         k, a, d, c, e.kind, e.addr, e.data, e.code);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en) begin
                if (wr_lat_pend) begin
                    wr_lat_pend = 1'b0;
                    chk("first_write_latency", cyc, wr_lat_cyc);
                end
                expect_evt(0, int'(reg_addr), int'(reg_wdata), 0);
            end
            if (pkt_done) expect_evt(1, 0, 0, 0);
            if (pkt_err)  expect_evt(2, 0, 0, int'(err_code));
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_valid     = 1'b1;
        rx_data      = b;
        rx_frame_err = fe;
        @(posedge clk); #1;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_pkt(input int addr, input int len, input bit bad_chk);
        logic [7:0] x;
        pb.delete(); pf.delete();
        pb.push_back(SYNC); pb.push_back(8'(addr)); pb.push_back(8'(len));
        x = 8'(addr) ^ 8'(len);
        for (int i = 0; i < ((len > MAX_LEN) ? 0 : len); i++) begin
            pb.push_back(8'($urandom));
            x ^= pb[pb.size() - 1];
        end
        if (bad_chk) x ^= 8'($urandom_range(255, 1));
        pb.push_back(x);
        for (int i = 0; i < pb.size(); i++) pf.push_back(1'b0);
    endtask

    // Packet-level reference: walks the byte list under the framing rules and queues the outcome.
    task automatic model_pkt(input int n_send, output int cut, output bit tmo, output bit pass);
        int a;
        int l;
        logic [7:0] x;
        cut = n_send; tmo = 1'b0; pass = 1'b0; a = 0; l = 0;
        for (int i = 1; i < n_send; i++) begin
            if (pf[i]) begin
                push_exp(2, 0, 0, 3); cut = i + 1; return;
            end
            if (i == 1) begin
                a = int'(pb[1]);
                if (a > 15) begin push_exp(2, 0, 0, 1); cut = 2; return; end
            end else if (i == 2) begin
                l = int'(pb[2]);
                if (l < 1 || l > MAX_LEN) begin push_exp(2, 0, 0, 1); cut = 3; return; end
            end else if (i == 3 + l) begin
                x = 8'd0;
                for (int j = 1; j <= 2 + l; j++) x ^= pb[j];
                if (pb[i] == x) begin
                    for (int j = 0; j < l; j++) push_exp(0, (a + j) % 16, int'(pb[3 + j]), 0);
                    push_exp(1, 0, 0, 0);
                    pass = 1'b1;
                end else begin
                    push_exp(2, 0, 0, 0);
                end
                cut = i + 1;
                return;
            end
        end
        tmo = 1'b1;
        push_exp(2, 0, 0, 2);
    endtask

    task automatic run_pkt(input int n_send, input int min_gap, input int max_gap, input bit stray);
        int cut;
        bit tmo;
        bit pass;
        chk("busy_idle_before_pkt", int'(busy), 0);
        model_pkt(n_send, cut, tmo, pass);
        for (int i = 0; i < cut; i++) begin
            send_byte(pb[i], pf[i]);
            if (pass && i == cut - 1) begin
                wr_lat_cyc  = cyc;
                wr_lat_pend = 1'b1;
            end else if (i < cut - 1) begin
                idle($urandom_range(max_gap, min_gap));
            end
        end
        if (pass && stray) send_byte(SYNC, 1'b0);
        if (tmo) idle(TO_CYC + 20);
        else     idle(MAX_LEN + 4 + $urandom_range(6, 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int r;
        int addr;
        int len;
        bit bad;
        int n_send;
        logic [7:0] b;

        idle(5);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_reg_wr_en", int'(reg_wr_en), 0);
        chk("rst_pkt_done", int'(pkt_done), 0);
        chk("rst_pkt_err", int'(pkt_err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_reg_addr_data", int'({reg_addr, reg_wdata}), 0);
        @(posedge clk); #1;

        // Basic packet, with a stray SYNC while committing that must be ignored.
        pb = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32};
        pf = '{0, 0, 0, 0, 0, 0};
        run_pkt(pb.size(), 0, 4, 1'b1);

        // Address wrap F -> 0.
        pb = '{8'hA5, 8'h0F, 8'h02, 8'hAA, 8'hBB, 8'h1C};
        pf = '{0, 0, 0, 0, 0, 0};
        run_pkt(pb.size(), 0, 4, 1'b0);

        // Bad checksum.
        pb = '{8'hA5, 8'h01, 8'h01, 8'h55, 8'h00};
        pf = '{0, 0, 0, 0, 0};
        run_pkt(pb.size(), 0, 4, 1'b0);

        // Length and address range errors.
        build_pkt(3, 0, 1'b0);    run_pkt(pb.size(), 0, 4, 1'b0);
        build_pkt(3, 9, 1'b0);    run_pkt(pb.size(), 0, 4, 1'b0);
        build_pkt(16, 2, 1'b0);   run_pkt(pb.size(), 0, 4, 1'b0);
        build_pkt(5, MAX_LEN, 1'b0); run_pkt(pb.size(), 0, 4, 1'b0);

        // Timeout after ADDR, then a clean packet.
        build_pkt(2, 3, 1'b0);    run_pkt(2, 0, 4, 1'b0);
        build_pkt(7, 3, 1'b0);    run_pkt(pb.size(), 0, 4, 1'b0);

        // Long but legal inter-byte gaps.
        build_pkt(9, 2, 1'b0);    run_pkt(pb.size(), TO_CYC - 50, TO_CYC - 50, 1'b0);

        // A framing-errored SYNC in IDLE is ignored.
        send_byte(SYNC, 1'b1);
        idle(2);
        send_byte(8'h00, 1'b0);
        idle(TO_CYC + 20);

        // Reset in the middle of DATA discards the packet silently.
        send_byte(8'hA5, 1'b0); idle(1);
        send_byte(8'h03, 1'b0); idle(1);
        send_byte(8'h04, 1'b0); idle(1);
        send_byte(8'h11, 1'b0); idle(1);
        send_byte(8'h22, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("midpkt_rst_busy", int'(busy), 0);
        chk("midpkt_rst_pkt_err", int'(pkt_err), 0);
        @(posedge clk); #1;
        build_pkt(12, 4, 1'b0);   run_pkt(pb.size(), 0, 4, 1'b0);

        for (int it = 0; it < 40; it++) begin
            r    = $urandom_range(9, 0);
            addr = $urandom_range(15, 0);
            len  = $urandom_range(MAX_LEN, 1);
            bad  = 1'b0;
            case (r)
                0: addr = $urandom_range(255, 16);
                1: len  = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(255, MAX_LEN + 1);
                2: bad  = 1'b1;
                default: ;
            endcase
            build_pkt(addr, len, bad);
            n_send = pb.size();
            if (r == 3) pf[$urandom_range(pb.size() - 1, 1)] = 1'b1;
            if (r == 4) n_send = $urandom_range(pb.size() - 1, 1);
            if ($urandom_range(3, 0) == 0) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send_byte(b, 1'b0);
                idle(1);
            end
            run_pkt(n_send, 0, 12, $urandom_range(1, 0) == 1);
        end

        idle(20);
        chk("scoreboard_empty", sbq.size(), 0);
        chk("write_latency_seen", int'(wr_lat_pend), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
